// File: rtl/life_pkg.sv
// Shared definitions for the life grid generation controller.
// The top recomputes cell count and index width from its own ROWS/COLS.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam int unsigned ROWS_DEF = 8;
    localparam int unsigned COLS_DEF = 8;
    localparam int unsigned NCELLS   = ROWS_DEF * COLS_DEF;
    localparam int unsigned IDX_W    = $clog2(NCELLS);

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/life_tick_div.sv
// Generation period counter for free-run mode.
// tick_o is combinational; the controller registers it onto enb.
module life_tick_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] lim;

    // >= rather than == so a live period decrease below the count fires at once
    always_comb begin
        lim    = (period_i == '0) ? '0 : period_i - DIV_W'(1);
        tick_o = en_i && (cnt_q >= lim);
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation controller for the life_cell array: serial load, clear,
// single step and free-run; sole driver of per-cell write and broadcast enb.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned GEN_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic                   load_bit,
    output logic                   load_ready,
    input  logic                   clear,
    input  logic                   step,
    input  logic                   run,
    input  logic [DIV_W-1:0]       period,
    output logic [ROWS*COLS-1:0]   cell_write,
    output logic                   cell_val,
    output logic                   enb,
    output logic                   load_done,
    output logic                   busy,
    output logic [GEN_W-1:0]       gen_count
);

    localparam int unsigned NC = ROWS * COLS;
    localparam int unsigned IW = idx_width(NC);

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [NC-1:0]   cell_write_q;
    logic            cell_val_q;
    logic            enb_q;
    logic            load_ready_q;
    logic            load_done_q;
    logic            busy_q;
    logic [GEN_W-1:0] gen_q;

    logic [NC-1:0]   onehot;
    logic            div_en;
    logic            tick;

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            onehot[i] = (idx_q == IW'(i));
        end
    end

    assign div_en = (state_q == RUN) && run;

    life_tick_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (div_en),
        .period_i (period),
        .tick_o   (tick)
    );

    // Write strobes are only ever set outside RUN and enb only in IDLE/RUN
    // without a write, so the two can never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cell_write_q <= '0;
            cell_val_q   <= 1'b0;
            enb_q        <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            gen_q        <= '0;
        end else begin
            cell_write_q <= '0;
            cell_val_q   <= 1'b0;
            enb_q        <= 1'b0;
            load_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q      <= LOAD;
                        idx_q        <= '0;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (clear) begin
                        state_q      <= CLEAR;
                        cell_write_q <= '1;
                        gen_q        <= '0;
                        busy_q       <= 1'b1;
                    end else if (run) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else if (step) begin
                        enb_q <= 1'b1;
                        gen_q <= gen_q + GEN_W'(1);
                    end
                end
                LOAD: begin
                    if (load_valid && load_ready_q) begin
                        cell_write_q <= onehot;
                        cell_val_q   <= load_bit;
                        if (idx_q == IW'(NC - 1)) begin
                            state_q      <= IDLE;
                            idx_q        <= '0;
                            load_ready_q <= 1'b0;
                            load_done_q  <= 1'b1;
                            busy_q       <= 1'b0;
                            gen_q        <= '0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                CLEAR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                RUN: begin
                    if (!run) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        enb_q <= 1'b1;
                        gen_q <= gen_q + GEN_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cell_write = cell_write_q;
    assign cell_val   = cell_val_q;
    assign enb        = enb_q;
    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign busy       = busy_q;
    assign gen_count  = gen_q;

endmodule
